mem_sram_controller: RTL



---
 rtl/mem_ctrl_pkg.sv | 26 ++
 rtl/sram_wait_counter.sv | 29 ++
 rtl/mem_sram_controller.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and defaults for the MEM-stage SRAM sequencer.
// Holds the state encoding and the byte-address to SRAM-offset helper.
package mem_ctrl_pkg;

    localparam int          DATA_W          = 32;
    localparam int          SRAM_DW         = 16;
    localparam int          DEF_WAIT_CYCLES = 3;
    localparam int          DEF_SRAM_AW     = 18;
    localparam logic [31:0] DEF_BASE_ADDR   = 32'd1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } mem_state_e;

    // Byte offset into the SRAM window; wraps modulo 2^32.
    function automatic logic [31:0] addr_offset(
        input logic [31:0] addr,
        input logic [31:0] base
    );
        return addr - base;
    endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Per-phase wait counter: load starts a phase of WAIT_CYCLES clocks,
// tc is high during the last clock of the phase.
module sram_wait_counter #(
    parameter int WAIT_CYCLES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic tc
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    logic [CW-1:0] cnt_q;

    // Reload at the start of each phase, then count down and park at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= CW'(WAIT_CYCLES - 1);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/mem_sram_controller.sv
// MEM-stage sequencer: splits 32-bit loads/stores into low then high
// 16-bit SRAM phases and holds ready low until the access completes.
module mem_sram_controller
    import mem_ctrl_pkg::*;
#(
    parameter int          WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter int          SRAM_AW     = DEF_SRAM_AW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_we_n
);

    localparam int WW = SRAM_AW - 1;

    mem_state_e    state_q;
    mem_state_e    state_d;
    logic          accept;
    logic          cnt_load;
    logic          cnt_tc;
    logic          phase;
    logic          op_wr_q;
    logic [WW-1:0] word_q;
    logic [15:0]   wdata_hi_q;
    logic [31:0]   offset;
    logic [WW-1:0] word_in;
    logic          unused_offset;

    assign offset        = addr_offset(address, BASE_ADDR);
    assign word_in       = offset[SRAM_AW:2];
    assign unused_offset = ^{offset[31:SRAM_AW+1], offset[1:0]};

    sram_wait_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait (
        .clk  (clk),
        .rst_n(rst_n),
        .load (cnt_load),
        .tc   (cnt_tc)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus phase-start strobes for the counter and latches.
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        cnt_load = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_write | mem_read) begin
                    accept   = 1'b1;
                    cnt_load = 1'b1;
                    state_d  = LO;
                end
            end
            LO: begin
                if (cnt_tc) begin
                    cnt_load = 1'b1;
                    state_d  = HI;
                end
            end
            HI: begin
                if (cnt_tc) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    // Latch the request, steer the SRAM bus and capture read halves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_wr_q     <= 1'b0;
            word_q      <= '0;
            wdata_hi_q  <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            read_data   <= '0;
        end else begin
            if (accept) begin
                op_wr_q   <= mem_write;
                word_q    <= word_in;
                sram_addr <= {word_in, 1'b0};
                if (mem_write) begin
                    wdata_hi_q  <= write_data[31:16];
                    sram_dq_out <= write_data[15:0];
                end
            end
            if ((state_q == LO) && cnt_tc) begin
                sram_addr <= {word_q, 1'b1};
                if (op_wr_q) begin
                    sram_dq_out <= wdata_hi_q;
                end else begin
                    read_data[15:0] <= sram_dq_in;
                end
            end
            if ((state_q == HI) && cnt_tc && !op_wr_q) begin
                read_data[31:16] <= sram_dq_in;
            end
        end
    end

    assign phase      = (state_q == LO) | (state_q == HI);
    assign sram_dq_oe = op_wr_q & phase;
    assign sram_we_n  = ~(op_wr_q & phase);
    assign ready      = ((state_q == IDLE) & ~mem_read & ~mem_write)
                      | (state_q == DONE);

endmodule
